// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: NOP encoding, default reset PC
// and the fetch state encoding used by the IF stage.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches one word at a time
// and feeds the IF/ID register; honours decode stall and EX redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_fetch_pc;
    logic         r_kill;
    logic [31:0]  r_hold_pc;
    logic [31:0]  r_hold_instr;
    logic [31:0]  r_pc_out;
    logic [31:0]  r_instr;
    logic         r_valid;

    fetch_state_e w_state_n;
    logic [31:0]  w_pc_n;
    logic [31:0]  w_fetch_pc_n;
    logic         w_kill_n;
    logic [31:0]  w_hold_pc_n;
    logic [31:0]  w_hold_instr_n;
    logic [31:0]  w_pc_out_n;
    logic [31:0]  w_instr_n;
    logic         w_valid_n;
    logic         w_load;
    logic [31:0]  w_load_pc;
    logic [31:0]  w_load_instr;
    logic [31:0]  w_redir_pc;

    assign imem_req        = (r_state == S_REQ) && !rst;
    assign imem_addr       = {r_pc[31:2], 2'b00};
    assign PC_out          = r_pc_out;
    assign instruction_out = r_instr;
    assign valid_out       = r_valid;
    assign w_redir_pc      = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_fetch_pc_n   = r_fetch_pc;
        w_kill_n       = r_kill;
        w_hold_pc_n    = r_hold_pc;
        w_hold_instr_n = r_hold_instr;
        w_pc_out_n     = r_pc_out;
        w_instr_n      = r_instr;
        w_valid_n      = r_valid;
        w_load         = 1'b0;
        w_load_pc      = r_fetch_pc;
        w_load_instr   = imem_rdata;

        case (r_state)
            S_REQ: begin
                if (imem_ready) begin
                    w_state_n = S_WAIT;
                    // A request accepted alongside a redirect is stale
                    if (redirect) begin
                        w_kill_n = 1'b1;
                    end else begin
                        w_fetch_pc_n = r_pc;
                        w_pc_n       = r_pc + 32'd4;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_n = S_REQ;
                    w_kill_n  = 1'b0;
                    if (!r_kill && !redirect) begin
                        if (!r_valid || !stall) begin
                            w_load = 1'b1;
                        end else begin
                            w_hold_pc_n    = r_fetch_pc;
                            w_hold_instr_n = imem_rdata;
                            w_state_n      = S_HOLD;
                        end
                    end
                end else if (redirect) begin
                    w_kill_n = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_state_n = S_REQ;
                end else if (!stall) begin
                    w_load       = 1'b1;
                    w_load_pc    = r_hold_pc;
                    w_load_instr = r_hold_instr;
                    w_state_n    = S_REQ;
                end
            end
            default: w_state_n = S_REQ;
        endcase

        if (w_load) begin
            w_pc_out_n = w_load_pc;
            w_instr_n  = w_load_instr;
            w_valid_n  = 1'b1;
        end else if (!stall) begin
            w_valid_n = 1'b0;
            w_instr_n = NOP_INSTR;
        end

        if (redirect) begin
            w_pc_n    = w_redir_pc;
            w_valid_n = 1'b0;
            w_instr_n = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_fetch_pc   <= 32'd0;
            r_kill       <= 1'b0;
            r_hold_pc    <= 32'd0;
            r_hold_instr <= 32'd0;
            r_pc_out     <= 32'd0;
            r_instr      <= NOP_INSTR;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_fetch_pc   <= w_fetch_pc_n;
            r_kill       <= w_kill_n;
            r_hold_pc    <= w_hold_pc_n;
            r_hold_instr <= w_hold_instr_n;
            r_pc_out     <= w_pc_out_n;
            r_instr      <= w_instr_n;
            r_valid      <= w_valid_n;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed + randomized bench for if_stage with a latency-variable
// memory and an in-order program-stream reference.
module tb_if_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    int errors = 0;
    int checks = 0;

    bit          pend = 1'b0;
    int          cnt  = 0;
    int          lat  = 0;
    logic [31:0] paddr = 32'd0;

    logic [31:0] exp_pc = RPC;
    int          consumed = 0;

    if_stage #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .PC_out         (PC_out),
        .instruction_out(instruction_out),
        .valid_out      (valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: reference bookkeeping before the edge, memory after it.
    task automatic step();
        logic        acc, rv, cons, redir, rs, hreq;
        logic [31:0] aaddr, haddr;
        acc   = imem_req && imem_ready;
        aaddr = imem_addr;
        rv    = imem_rvalid;
        rs    = rst;
        redir = redirect && !rst;
        cons  = valid_out && !stall && !redirect && !rst;
        hreq  = imem_req && !imem_ready && !redirect && !rst;
        haddr = imem_addr;
        if (cons) begin
            chk("pc_order", PC_out, exp_pc);
            chk("instr_data", instruction_out, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        if (acc) chk("one_outstanding", {31'd0, pend || rv}, 32'd0);
        if (redir) exp_pc = redirect_pc & 32'hFFFF_FFFC;
        if (rs) exp_pc = RPC;
        @(negedge clk);
        if (hreq) begin
            chk("req_stable", {31'd0, imem_req}, 32'd1);
            chk("addr_stable", imem_addr, haddr);
        end
        if (redir) chk("flush_valid", {31'd0, valid_out}, 32'd0);
        if (!valid_out) chk("nop_when_empty", instruction_out, NOP);
        if (rs) pend = 1'b0;
        else if (acc) begin
            pend  = 1'b1;
            paddr = aaddr;
            cnt   = lat;
        end
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) begin
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = paddr ^ KEY;
                pend        = 1'b0;
            end else begin
                cnt--;
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;

        // reset state
        step();
        step();
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_pc_out", PC_out, 32'd0);
        chk("rst_instr", instruction_out, NOP);
        chk("rst_req", {31'd0, imem_req}, 32'd0);

        // 1: straight-line fetch
        rst = 1'b0;
        #1;
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr0", imem_addr, 32'h100);
        step();
        chk("t1_wait_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("t1_valid", {31'd0, valid_out}, 32'd1);
        chk("t1_pc", PC_out, 32'h100);
        chk("t1_instr", instruction_out, 32'hA5A5_A4A5);
        chk("t1_addr1", imem_addr, 32'h104);

        // 2: stall across the 0x104 response
        stall = 1'b1;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chk("t2_no_req", {31'd0, imem_req}, 32'd0);
            chk("t2_pc_hold", PC_out, 32'h100);
            chk("t2_valid_hold", {31'd0, valid_out}, 32'd1);
            if (i < 2) step();
        end
        stall = 1'b0;
        step();
        chk("t2_pc_next", PC_out, 32'h104);
        chk("t2_valid", {31'd0, valid_out}, 32'd1);
        chk("t2_addr", imem_addr, 32'h108);

        // 3: redirect while waiting for 0x108
        lat = 3;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        chk("t3_valid", {31'd0, valid_out}, 32'd0);
        step();
        step();
        chk("t3_still_wait", {31'd0, imem_req}, 32'd0);
        step();
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h200);
        lat = 0;
        step();
        step();
        chk("t3_pc", PC_out, 32'h200);
        chk("t3_valid_new", {31'd0, valid_out}, 32'd1);

        // 4: redirect + stall + rvalid with hold occupied
        stall = 1'b1;
        step();
        step();
        chk("t4_in_hold", {31'd0, imem_req}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        imem_rvalid = 1'b1;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        chk("t4_valid", {31'd0, valid_out}, 32'd0);
        chk("t4_instr", instruction_out, NOP);
        chk("t4_addr", imem_addr, 32'h300);
        step();
        step();
        chk("t4_pc", PC_out, 32'h300);

        // 5: wrap at top of address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        step();
        chk("t5_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        step();
        chk("t5_pc", PC_out, 32'hFFFF_FFFC);
        chk("t5_addr1", imem_addr, 32'h0000_0000);

        // 6: reset while a response is outstanding
        step();
        rst = 1'b1;
        step();
        chk("t6_valid", {31'd0, valid_out}, 32'd0);
        chk("t6_pc", PC_out, 32'd0);
        chk("t6_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0;
        #1;
        chk("t6_req_after", {31'd0, imem_req}, 32'd1);
        chk("t6_addr", imem_addr, RPC);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            imem_ready  = ($urandom_range(0, 3) != 0);
            lat         = $urandom_range(0, 3);
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 29) == 0);
            redirect_pc = $urandom;
            rst         = ($urandom_range(0, 299) == 0);
            step();
        end
        chk("progress", {31'd0, consumed > 150}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage that sits directly upstream of the decode stage. It owns the program counter and issues word fetches to instruction memory over a request/response handshake with one request outstanding. It drives the IF/ID pipeline register (PC_out, instruction_out, valid_out). It honours stalls from decode and redirects (taken branch or jump) from execute.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
NOP_INSTR, 32'h0000_0013, instruction placed on instruction_out when empty or flushed (addi x0,x0,0).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  decode cannot accept; hold IF/ID register
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  redirect target; bits [1:0] ignored
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  fetched instruction
PC_out  out  32  PC of instruction in IF/ID register
instruction_out  out  32  instruction to decode
valid_out  out  1  IF/ID register holds a real instruction

Behaviour:
- Reset (rst=1 at edge): pc_q=RESET_PC, state=S_REQ, kill=0, hold buffer empty, PC_out=0, instruction_out=NOP_INSTR, valid_out=0. imem_req is 0 while rst=1. The first request is issued in the first cycle after rst deasserts.
- imem_req = (state==S_REQ) && !rst, driven combinationally. imem_addr = {pc_q[31:2],2'b00}. Request and address stay stable until imem_ready.
- States:
  - S_REQ: on imem_req && imem_ready, set fetch_pc<=pc_q, pc_q<=pc_q+4 (mod 2^32), and go to S_WAIT.
  - S_WAIT: wait for imem_rvalid. If kill=1, discard the data, clear kill, and go to S_REQ. Otherwise, if the IF/ID register is free (valid_out==0 or stall==0), load PC_out<=fetch_pc, instruction_out<=imem_rdata, valid_out<=1, and go to S_REQ. Otherwise, store {fetch_pc, rdata} in the hold buffer and go to S_HOLD.
  - S_HOLD: when stall==0, move the hold buffer into the IF/ID register (valid_out<=1) and go to S_REQ.
- IF/ID register:
  - stall=1: PC_out, instruction_out and valid_out hold their values.
  - stall=0 with no load this cycle: valid_out<=0 (the instruction was consumed) and instruction_out<=NOP_INSTR.
- imem_rvalid is sampled only in S_WAIT; it is ignored in other states.
- Throughput: at most one instruction per 2 cycles with zero-wait memory (request at t, rvalid at t+1, next request at t+2). Memory latency is unbounded.
- Redirect has highest priority and overrides stall in the same cycle:
  - pc_q<=redirect_pc & ~3; valid_out<=0; instruction_out<=NOP_INSTR; hold buffer cleared.
  - In S_REQ with imem_ready=1: the accepted request is stale, so go to S_WAIT with kill<=1; pc_q is not incremented.
  - In S_REQ with imem_ready=0: stay in S_REQ; the new address is presented next cycle.
  - In S_WAIT without rvalid: set kill<=1 and stay in S_WAIT.
  - In S_WAIT with rvalid: discard the data and go to S_REQ.
  - In S_HOLD: go to S_REQ.
- A redirect while kill is already 1 only updates pc_q.
- Reset mid-operation aborts everything with no wait for the outstanding response. Instruction memory is reset by the same rst and drops in-flight requests.
- The block raises no misalignment or fault signalling; both are out of scope.

Decomposition:
- Shared pipeline package holds NOP_INSTR, the default RESET_PC, and the fetch state encoding (S_REQ, S_WAIT, S_HOLD). Decode and flush logic use the same NOP constant.
- Single module, no sub-module. The hold buffer is a single entry and stays inline.

Test Plan:
1. RESET_PC=0x100, imem_ready=1, rvalid one cycle after accept, rdata=addr^0xA5A5A5A5 -> imem_addr sequence 0x100, 0x104, 0x108; valid_out=1 with PC_out=0x100 and instruction_out=0xA5A5A4A5 in the cycle after the first rvalid.
2. stall=1 from before the 0x104 response until 4 cycles later -> response held in S_HOLD, PC_out stays 0x100, no new imem_req. After stall drops, PC_out=0x104 next cycle; no instruction lost or duplicated.
3. Redirect to 0x203 while in S_WAIT for 0x108, rvalid arrives 3 cycles later -> that response is dropped, valid_out=0 the cycle after redirect, next imem_addr=0x200, first valid PC_out=0x200.
4. redirect, stall and imem_rvalid all high in one cycle with S_HOLD occupied -> valid_out=0, instruction_out=0x00000013, hold cleared, next imem_addr=redirect target.
5. Redirect to 0xFFFFFFFC -> fetches 0xFFFFFFFC then 0x00000000.
6. rst pulsed while in S_WAIT -> next cycle valid_out=0, PC_out=0, imem_req=0; one cycle later imem_req=1 with imem_addr=RESET_PC.
